ucsbece154b_fifo_push_arbiter: RTL and testbench
================================================

# ucsbece154b_fifo_push_arbiter

Round-robin arbiter that shares the single push port of one `ucsbece154b_fifo` instance among `NR_REQ` producers. It uses a valid/ready handshake, a burst lock that lets a winner push up to `MAX_BURST` consecutive words, and full-with-pop pass-through that matches the FIFO's accept rule. It sits between the producers (e.g. fetch/response sources) and the FIFO's `data_i`/`push_i`/`full_o`/`pop_i` nets.

## Interface
- `DATA_WIDTH`, 32: width of each pushed word.
- `NR_REQ`, 4: number of requesters; must be ≥2.
- `MAX_BURST`, 2: max consecutive accepted pushes by one owner before rotation; must be ≥1.
- `clk_i` in 1: single clock, all state updates on posedge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in `NR_REQ`: requester *i* has a word.
- `req_data_i` in `NR_REQ`×`DATA_WIDTH`: per-requester word.
- `req_ready_o` out `NR_REQ`: one-hot or zero; high means the word is accepted this cycle.
- `fifo_full_i` in 1: FIFO `full_o`.
- `fifo_pop_i` in 1: the FIFO consumer's `pop_i`, observed so the arbiter can push into a full FIFO.
- `fifo_data_o` out `DATA_WIDTH`: to FIFO `data_i`; equals the winner's data, 0 when there is no winner.
- `fifo_push_o` out 1: to FIFO `push_i`.
- `grant_id_o` out `$clog2(NR_REQ)`: current winner index; 0 when there is no winner.
- `locked_o` out 1: a burst lock is held.

## Operation
- `accept = !fifo_full_i || fifo_pop_i`, which is identical to the FIFO's internal push enable.
- Registered state:
  - `state` ∈ {OPEN, LOCK}.
  - `owner`.
  - `rr_ptr`, the first index searched.
  - `burst_cnt`, width `$clog2(MAX_BURST+1)`.
- Winner selection, combinational:
  - If `state==LOCK && req_valid_i[owner]`, the winner is `owner`.
  - Otherwise the winner is the first valid index searching `rr_ptr`, `rr_ptr+1`, … mod `NR_REQ`.
  - If no requester is valid, there is no winner.
- `fifo_push_o = winner_exists && accept && !rst_i`.
- `req_ready_o[winner] = fifo_push_o`. All other bits are 0.
- A transfer is a cycle with `fifo_push_o=1`. On each transfer `rr_ptr <= (winner+1) mod NR_REQ`, wrapping from `NR_REQ-1` to 0.
- State transitions:
  - OPEN, transfer, `MAX_BURST>1`: go to LOCK; `owner <= winner`; `burst_cnt <= 1`.
  - OPEN, transfer, `MAX_BURST==1`: stay OPEN.
  - LOCK, transfer by `owner`, `burst_cnt+1 == MAX_BURST`: go to OPEN; `burst_cnt <= 0`.
  - LOCK, transfer by `owner`, otherwise: `burst_cnt++`.
  - LOCK, `req_valid_i[owner]==0`: go to OPEN. The same cycle arbitrates round-robin, so a transfer by another requester may occur. If it does, the OPEN transfer rule applies and a new lock starts.
  - LOCK, owner valid but `!accept` (stall): hold all state.
- Once a requester asserts valid it is required to hold valid and data until ready.
- The arbiter does not check this rule; a violation causes the word to be dropped silently.

## Timing
- Zero-latency grant: `req_ready_o`, `fifo_push_o` and `fifo_data_o` are combinational from inputs and registered state.
- The word is written into the FIFO at the same posedge as the ready handshake.
- Throughput: one word per cycle while `accept` holds.
- Reset values, registers: `state=OPEN`, `owner=0`, `rr_ptr=0`, `burst_cnt=0`.
- Reset values, outputs: `fifo_push_o=0`, `req_ready_o=0`, `locked_o=0`, `grant_id_o` and `fifo_data_o` follow the combinational winner.
- Reset mid-burst: the lock is dropped. The next cycle arbitrates from index 0.
- FIFO full with `fifo_pop_i=1`: a push occurs, matching the FIFO's replacement behaviour.
- FIFO full with `fifo_pop_i=0`: no ready; the lock and `rr_ptr` are held.
- Single requester continuously valid: it receives bursts of `MAX_BURST`, with no idle cycle between bursts, because it wins OPEN again.

## Structure
- Package `ucsbece154b_arb_pkg`:
  - `arb_state_e` {OPEN, LOCK}.
  - Localparam helper for `ID_W = $clog2(NR_REQ)`.
- Sub-module `ucsbece154b_rr_picker`: purely combinational. Inputs are the valid vector and the start pointer; outputs are `found` and `index`. It is reusable by the pop side later.
- The top module holds the FSM, counters and muxes, and instantiates the FIFO in the testbench only.

## Test plan
- **Reset:** `rst_i` high 2 cycles with all `req_valid_i=4'b1111` → `fifo_push_o=0`, `req_ready_o=0`. First post-reset cycle → grant 0.
- **Burst rotation:** `NR_REQ=4`, `MAX_BURST=2`, all valid continuously, FIFO never full → grant sequence 0,0,1,1,2,2,3,3,0,0.
- **Owner drops mid-burst:** req0 valid one cycle only, req2 valid throughout → grant 0 then 2 on the next cycle, with no bubble; `locked_o` then reflects the req2 lock.
- **Full stall:**
  - Setup: `fifo_full_i=1`, `fifo_pop_i=0` for 3 cycles while req1 is locked with `burst_cnt=1`.
  - During the stall → no ready.
  - Then `fifo_pop_i=1` → req1 gets exactly one more push, then unlock.
- **Wrap-around:** only req3 and req0 valid, `rr_ptr=3` → req3 ×2, then req0 ×2, then req3. Run against a real FIFO: the pop order is 3a,3b,0a,0b.
- **Reset mid-burst:** req2 locked after 1 push, assert `rst_i` → next cycle `state=OPEN`. With req2 and req0 valid → winner 0.

Source files
------------

// File: rtl/ucsbece154b_fifo_push_arbiter_pkg.sv
// Shared types and sizing helpers for the FIFO push arbiter and its pickers.
package ucsbece154b_arb_pkg;

  typedef enum logic {
    OPEN = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Index width for n requesters; never collapses to zero bits.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Burst counter width able to hold the value max_burst.
  function automatic int unsigned burst_width(input int unsigned max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/ucsbece154b_fifo_push_arbiter_if.sv
// Producer/FIFO-side nets of the push arbiter; slave is the arbiter's view.
interface ucsbece154b_fifo_push_arbiter_if
  import ucsbece154b_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NR_REQ     = 4
);
  localparam int unsigned ID_W = id_width(NR_REQ);

  logic [NR_REQ-1:0]                 req_valid_i;
  logic [NR_REQ-1:0][DATA_WIDTH-1:0] req_data_i;
  logic [NR_REQ-1:0]                 req_ready_o;
  logic                              fifo_full_i;
  logic                              fifo_pop_i;
  logic [DATA_WIDTH-1:0]             fifo_data_o;
  logic                              fifo_push_o;
  logic [ID_W-1:0]                   grant_id_o;
  logic                              locked_o;

  modport slave (
    input  req_valid_i, req_data_i, fifo_full_i, fifo_pop_i,
    output req_ready_o, fifo_data_o, fifo_push_o, grant_id_o, locked_o
  );

  modport master (
    output req_valid_i, req_data_i, fifo_full_i, fifo_pop_i,
    input  req_ready_o, fifo_data_o, fifo_push_o, grant_id_o, locked_o
  );

endinterface

// File: rtl/ucsbece154b_fifo_push_arbiter_rr_picker.sv
// Combinational round-robin search: first set bit of valid_i at or after start_i, wrapping.
module ucsbece154b_rr_picker
  import ucsbece154b_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] index_o
);

  logic [IW-1:0] idx;

  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(start_i) + k) % N);
      if (!found_o && valid_i[idx]) begin
        found_o = 1'b1;
        index_o = idx;
      end
    end
  end

endmodule

// File: rtl/ucsbece154b_fifo_push_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO push port among NR_REQ producers.
module ucsbece154b_fifo_push_arbiter
  import ucsbece154b_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NR_REQ     = 4,
  parameter int unsigned MAX_BURST  = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  ucsbece154b_fifo_push_arbiter_if.slave    bus
);

  localparam int unsigned ID_W = id_width(NR_REQ);
  localparam int unsigned BC_W = burst_width(MAX_BURST);
  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NR_REQ - 1);
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST);
  localparam logic [BC_W-1:0] BURST_ONE  = BC_W'(1);
  localparam bit              USE_LOCK   = (MAX_BURST > 1);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0] burst_cnt_q, burst_cnt_d;

  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic            owner_valid;
  logic            owner_hold;
  logic            winner_exists;
  logic [ID_W-1:0] winner;
  logic            accept;
  logic            push;

  ucsbece154b_rr_picker #(
    .N (NR_REQ)
  ) u_picker (
    .valid_i (bus.req_valid_i),
    .start_i (rr_ptr_q),
    .found_o (pick_found),
    .index_o (pick_idx)
  );

  // A held lock overrides the round-robin pick only while its owner still has data.
  always_comb begin
    owner_valid   = bus.req_valid_i[owner_q];
    owner_hold    = (state_q == LOCK) && owner_valid;
    winner_exists = owner_hold || pick_found;
    winner        = owner_hold ? owner_q : pick_idx;
    accept        = !bus.fifo_full_i || bus.fifo_pop_i;
    push          = winner_exists && accept && !rst_i;
  end

  always_comb begin
    bus.fifo_push_o = push;
    bus.req_ready_o = '0;
    if (push) begin
      bus.req_ready_o[winner] = 1'b1;
    end
    bus.fifo_data_o = winner_exists ? bus.req_data_i[winner] : '0;
    bus.grant_id_o  = winner_exists ? winner : '0;
    bus.locked_o    = (state_q == LOCK);
  end

  // Next-state: rotate pointer on every transfer, open/extend/close burst locks.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;

    if (push) begin
      rr_ptr_d = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
    end

    case (state_q)
      OPEN: begin
        if (push && USE_LOCK) begin
          state_d     = LOCK;
          owner_d     = winner;
          burst_cnt_d = BURST_ONE;
        end
      end
      LOCK: begin
        if (!owner_valid) begin
          state_d     = OPEN;
          burst_cnt_d = '0;
          if (push && USE_LOCK) begin
            state_d     = LOCK;
            owner_d     = winner;
            burst_cnt_d = BURST_ONE;
          end
        end else if (push) begin
          if (burst_cnt_q + BURST_ONE == BURST_LAST) begin
            state_d     = OPEN;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + BURST_ONE;
          end
        end
      end
      default: begin
        state_d     = OPEN;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= OPEN;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_ucsbece154b_fifo_push_arbiter.sv
// Scoreboard bench: driver predicts each cycle from an abstract arbitration model, monitor compares.
module tb_ucsbece154b_fifo_push_arbiter;
  import ucsbece154b_arb_pkg::*;

  localparam int DW    = 32;
  localparam int N     = 4;
  localparam int MB    = 2;
  localparam int DEPTH = 8;
  localparam int unsigned ID_W = id_width(N);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ucsbece154b_fifo_push_arbiter_if #(.DATA_WIDTH(DW), .NR_REQ(N)) bus ();

  ucsbece154b_fifo_push_arbiter #(
    .DATA_WIDTH (DW),
    .NR_REQ     (N),
    .MAX_BURST  (MB)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    bit              push;
    logic [N-1:0]    ready;
    logic [ID_W-1:0] gid;
    logic [DW-1:0]   data;
    bit              locked;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] gold_q[$];
  logic [DW-1:0] fq[$];
  int            seen_g[$];
  int            seen_pop[$];
  int            want[$];
  int            total = 0;
  int            bad   = 0;
  bit            rec_g   = 1'b0;
  bit            rec_pop = 1'b0;

  // Abstract model: lock owner, words left in burst, next search start.
  bit            m_lock;
  int            m_owner;
  int            m_cnt;
  int            m_rr;
  logic [DW-1:0] cur_data [N];

  function automatic logic [DW-1:0] new_word(input int i);
    return {8'(i), 24'($urandom)};
  endfunction

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    return v[ID_W'(i)];
  endfunction

  task automatic drive(input logic [N-1:0] v, input bit ff, input bit pp, input bit r,
                       output logic [N-1:0] rdy);
    int   win;
    bit   full;
    bit   acc;
    bit   push;
    exp_t e;
    @(negedge clk);
    full = ff || (fq.size() >= DEPTH);
    rst  = r;
    bus.req_valid_i = v;
    bus.fifo_full_i = full;
    bus.fifo_pop_i  = pp;
    for (int i = 0; i < N; i++)
      bus.req_data_i[ID_W'(i)] = bit_of(v, i) ? cur_data[ID_W'(i)] : DW'($urandom);
    win = -1;
    if (m_lock && bit_of(v, m_owner)) win = m_owner;
    else
      for (int k = 0; k < N; k++)
        if (win < 0 && bit_of(v, (m_rr + k) % N)) win = (m_rr + k) % N;
    acc      = !full || pp;
    push     = (win >= 0) && acc && !r;
    e.push   = push;
    e.ready  = push ? N'(1 << win) : '0;
    e.gid    = (win >= 0) ? ID_W'(win) : '0;
    e.data   = (win >= 0) ? cur_data[ID_W'(win)] : '0;
    e.locked = m_lock;
    exp_q.push_back(e);
    rdy = e.ready;
    if (r) begin
      m_lock = 1'b0; m_owner = 0; m_cnt = 0; m_rr = 0;
    end else begin
      if (m_lock && !bit_of(v, m_owner)) begin
        m_lock = 1'b0; m_cnt = 0;
      end
      if (push) begin
        gold_q.push_back(cur_data[ID_W'(win)]);
        cur_data[ID_W'(win)] = new_word(win);
        m_rr = (win + 1) % N;
        if (m_lock) begin
          m_cnt++;
          if (m_cnt == MB) begin m_lock = 1'b0; m_cnt = 0; end
        end else if (MB > 1) begin
          m_lock = 1'b1; m_owner = win; m_cnt = 1;
        end
      end
    end
    #2;
  endtask

  // Monitor: per-cycle output check, plus a queue standing in for the real FIFO.
  always @(negedge clk) begin
    exp_t          e;
    logic [DW-1:0] w;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (bus.fifo_push_o !== e.push || bus.req_ready_o !== e.ready ||
          bus.grant_id_o !== e.gid || bus.fifo_data_o !== e.data ||
          bus.locked_o !== e.locked) begin
        bad++;
        $display("FAIL cycle t=%0t: push %0b want %0b, ready %b want %b, gid %0d want %0d, data %h want %h, locked %0b want %0b",
                 $time, bus.fifo_push_o, e.push, bus.req_ready_o, e.ready, bus.grant_id_o, e.gid,
                 bus.fifo_data_o, e.data, bus.locked_o, e.locked);
      end
    end
    if (rec_g && bus.fifo_push_o) seen_g.push_back(int'(bus.grant_id_o));
    if (bus.fifo_pop_i && fq.size() > 0) begin
      w = fq.pop_front();
      if (rec_pop) seen_pop.push_back(int'(w[DW-1:DW-8]));
      total++;
      if (gold_q.size() == 0) begin
        bad++;
        $display("FAIL fifo_order: popped %h, no word expected", w);
      end else begin
        if (w !== gold_q[0]) begin
          bad++;
          $display("FAIL fifo_order: popped %h want %h", w, gold_q[0]);
        end
        void'(gold_q.pop_front());
      end
    end
    if (bus.fifo_push_o) fq.push_back(bus.fifo_data_o);
  end

  task automatic check_seq(input string name, input bit use_pop);
    int got[$];
    if (use_pop) got = seen_pop;
    else         got = seen_g;
    total++;
    if (got.size() != want.size()) begin
      bad++;
      $display("FAIL %s: %0d entries, want %0d", name, got.size(), want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) begin
        total++;
        if (got[i] != want[i]) begin
          bad++;
          $display("FAIL %s[%0d]: got %0d want %0d", name, i, got[i], want[i]);
        end
      end
    end
    seen_g.delete();
    seen_pop.delete();
  endtask

  initial begin
    logic [N-1:0] rdy;
    logic [N-1:0] v;
    logic [N-1:0] pend;
    rst = 1'b1;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.fifo_full_i = 1'b0;
    bus.fifo_pop_i  = 1'b0;
    m_lock = 1'b0; m_owner = 0; m_cnt = 0; m_rr = 0;
    for (int i = 0; i < N; i++) cur_data[i] = new_word(i);

    // Reset with everyone requesting, then burst rotation.
    drive(4'b1111, 1'b0, 1'b1, 1'b1, rdy);
    drive(4'b1111, 1'b0, 1'b1, 1'b1, rdy);
    rec_g = 1'b1;
    repeat (10) drive(4'b1111, 1'b0, 1'b1, 1'b0, rdy);
    rec_g = 1'b0;
    want = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    check_seq("rotation", 1'b0);

    // Owner drops mid-burst: hand-off with no bubble.
    drive(4'b0000, 1'b0, 1'b1, 1'b1, rdy);
    rec_g = 1'b1;
    drive(4'b0101, 1'b0, 1'b1, 1'b0, rdy);
    drive(4'b0100, 1'b0, 1'b1, 1'b0, rdy);
    drive(4'b0100, 1'b0, 1'b1, 1'b0, rdy);
    rec_g = 1'b0;
    want = '{0, 2, 2};
    check_seq("owner_drop", 1'b0);

    // Full stall holds the lock; full-with-pop lets the last burst word through.
    drive(4'b0000, 1'b0, 1'b1, 1'b1, rdy);
    rec_g = 1'b1;
    drive(4'b0010, 1'b0, 1'b1, 1'b0, rdy);
    repeat (3) drive(4'b0010, 1'b1, 1'b0, 1'b0, rdy);
    drive(4'b0010, 1'b1, 1'b1, 1'b0, rdy);
    drive(4'b0010, 1'b0, 1'b1, 1'b0, rdy);
    rec_g = 1'b0;
    want = '{1, 1, 1};
    check_seq("full_stall", 1'b0);

    // Wrap-around from rr_ptr=3, then pop order out of the FIFO.
    repeat (12) drive(4'b0000, 1'b0, 1'b1, 1'b0, rdy);
    drive(4'b0000, 1'b0, 1'b0, 1'b1, rdy);
    drive(4'b0100, 1'b0, 1'b0, 1'b0, rdy);
    rec_g = 1'b1;
    repeat (5) drive(4'b1001, 1'b0, 1'b0, 1'b0, rdy);
    rec_g = 1'b0;
    want = '{3, 3, 0, 0, 3};
    check_seq("wrap", 1'b0);
    rec_pop = 1'b1;
    repeat (8) drive(4'b0000, 1'b0, 1'b1, 1'b0, rdy);
    rec_pop = 1'b0;
    want = '{2, 3, 3, 0, 0, 3};
    check_seq("pop_order", 1'b1);

    // Reset mid-burst: next arbitration restarts at index 0.
    rec_g = 1'b1;
    drive(4'b0100, 1'b0, 1'b1, 1'b0, rdy);
    drive(4'b0101, 1'b0, 1'b1, 1'b1, rdy);
    drive(4'b0101, 1'b0, 1'b1, 1'b0, rdy);
    rec_g = 1'b0;
    want = '{2, 0};
    check_seq("reset_mid_burst", 1'b0);

    // Random traffic honouring hold-until-ready.
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      v = pend;
      for (int i = 0; i < N; i++)
        if (!v[ID_W'(i)] && $urandom_range(0, 99) < 55) v[ID_W'(i)] = 1'b1;
      drive(v, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) == 0, rdy);
      pend = v & ~rdy;
    end

    for (int c = 0; c < 64 && fq.size() > 0; c++) drive(4'b0000, 1'b0, 1'b1, 1'b0, rdy);
    total++;
    if (gold_q.size() != 0 || fq.size() != 0) begin
      bad++;
      $display("FAIL drain: fifo holds %0d words, expected %0d", fq.size(), gold_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
